// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: run control, next-PC decisions, program loader and fetch results.
// The slave modport is the fetch unit's view; the master modport is the driver's view.
interface instr_fetch_unit_if;
   logic        start;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic        imem_wr_en;
   logic [15:0] imem_wr_addr;
   logic [31:0] imem_wr_data;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  state;
   logic        halted;
   logic        fetch_err;
   logic [31:0] retired;

   modport slave (
      input  start, stall, branch, zero, jump, imem_wr_en, imem_wr_addr, imem_wr_data,
      output instr, opcode, pc, pc_plus4, state, halted, fetch_err, retired
   );

   modport master (
      output start, stall, branch, zero, jump, imem_wr_en, imem_wr_addr, imem_wr_data,
      input  instr, opcode, pc, pc_plus4, state, halted, fetch_err, retired
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, word-addressed instruction memory, next-PC selection
// and an IDLE/RUN/HALT run-control FSM that gates execution and program loading.
module instr_fetch_unit #(
   parameter int unsigned IMEM_DEPTH  = 64,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input logic              clk,
   input logic              reset,
   instr_fetch_unit_if.slave bus
);
   localparam int unsigned AW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHalt = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] retired_q, retired_d;
   logic        fetch_err_q, fetch_err_d;

   logic [31:0] mem [IMEM_DEPTH];

   logic        in_range;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic        wr_ok;

   assign in_range = ({2'b00, pc_q[31:2]} < DEPTH_W);

   // Outside RUN or out of range the fetched word is a NOP so the control unit idles.
   always_comb begin
      instr = '0;
      if (state_q == StRun && in_range) begin
         instr = mem[pc_q[AW+1:2]];
      end
   end

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (bus.jump) begin
         next_pc = jump_target;
      end else if (bus.branch && bus.zero) begin
         next_pc = branch_target;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      retired_d   = retired_q;
      fetch_err_d = fetch_err_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // Range fault wins over stall so a stalled wild PC still stops fetch.
            if (!in_range) begin
               state_d     = StHalt;
               fetch_err_d = 1'b1;
            end else if (!bus.stall) begin
               retired_d = retired_q + 32'd1;
               if (instr[31:26] == HALT_OPCODE) begin
                  state_d = StHalt;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         StHalt: begin
            if (bus.start) begin
               state_d     = StIdle;
               pc_d        = RESET_PC;
               retired_d   = '0;
               fetch_err_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         retired_q   <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         retired_q   <= retired_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // Memory has no reset so a program survives a mid-run reset.
   assign wr_ok = bus.imem_wr_en && !reset && (state_q != StRun) &&
                  ({16'h0000, bus.imem_wr_addr} < DEPTH_W);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[bus.imem_wr_addr[AW-1:0]] <= bus.imem_wr_data;
      end
   end

   assign bus.instr     = instr;
   assign bus.opcode    = instr[31:26];
   assign bus.pc        = pc_q;
   assign bus.pc_plus4  = pc_plus4;
   assign bus.state     = state_q;
   assign bus.halted    = (state_q == StHalt);
   assign bus.fetch_err = fetch_err_q;
   assign bus.retired   = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model; a second 4-word instance covers range faults.
module tb_instr_fetch_unit;
   localparam int unsigned DEPTH = 64;

   logic clk = 1'b0;
   logic reset;
   logic reset4;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus4 ();

   instr_fetch_unit #(.IMEM_DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   instr_fetch_unit #(.IMEM_DEPTH(4)) u_dut4 (
      .clk   (clk),
      .reset (reset4),
      .bus   (bus4)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: 0 idle, 1 run, 2 halt
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc;
   logic [31:0] m_ret;
   int          m_st;
   bit          m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_instr();
      if (m_st == 1 && (m_pc / 4) < DEPTH) return m_mem[m_pc / 4];
      return 32'h0;
   endfunction

   task automatic check_all();
      logic [31:0] ei;
      ei = m_instr();
      check("instr", bus.instr, ei);
      check("opcode", {26'h0, bus.opcode}, {26'h0, ei[31:26]});
      check("pc", bus.pc, m_pc);
      check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      check("state", {30'h0, bus.state}, 32'(m_st));
      check("halted", {31'h0, bus.halted}, {31'h0, m_st == 2});
      check("fetch_err", {31'h0, bus.fetch_err}, {31'h0, m_err});
      check("retired", bus.retired, m_ret);
   endtask

   task automatic model_step(input bit rst, input bit st, input bit stl, input bit br,
                             input bit z, input bit j, input bit we,
                             input logic [15:0] a, input logic [31:0] d);
      logic [31:0] ins;
      logic [31:0] off;
      if (rst) begin
         m_pc = 32'h0; m_st = 0; m_err = 0; m_ret = 0;
         return;
      end
      if (we && m_st != 1 && a < DEPTH) m_mem[a] = d;
      case (m_st)
         0: if (st) m_st = 1;
         1: begin
            if ((m_pc / 4) >= DEPTH) begin
               m_st = 2; m_err = 1;
            end else if (!stl) begin
               ins = m_mem[m_pc / 4];
               m_ret = m_ret + 1;
               if (ins[31:26] == 6'h3F) m_st = 2;
               else if (j) m_pc = ((m_pc + 4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
               else if (br && z) begin
                  off = 32'($signed(ins[15:0])) * 4;
                  m_pc = m_pc + 4 + off;
               end else m_pc = m_pc + 4;
            end
         end
         default: if (st) begin
            m_st = 0; m_pc = 32'h0; m_ret = 0; m_err = 0;
         end
      endcase
   endtask

   task automatic cycle(input bit rst, input bit st, input bit stl, input bit br, input bit z,
                        input bit j, input bit we, input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      reset = rst; bus.start = st; bus.stall = stl; bus.branch = br; bus.zero = z;
      bus.jump = j; bus.imem_wr_en = we; bus.imem_wr_addr = a; bus.imem_wr_data = d;
      #1;
      if (chk_en) check_all();
      @(posedge clk);
      model_step(rst, st, stl, br, z, j, we, a, d);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
   endtask

   task automatic load(input logic [15:0] a, input logic [31:0] d);
      cycle(0, 0, 0, 0, 0, 0, 1, a, d);
   endtask

   task automatic pulse_start();
      cycle(0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_word();
      logic [5:0]  op;
      logic [25:0] low;
      op  = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      low = ($urandom_range(0, 3) != 0) ? 26'($urandom_range(0, 70))
                                        : {10'h0, 16'($urandom_range(16'hFFC0, 16'hFFFF))};
      return {op, low};
   endfunction

   initial begin
      reset = 1'b1;
      reset4 = 1'b1;
      bus4.start = 0; bus4.stall = 0; bus4.branch = 0; bus4.zero = 0; bus4.jump = 0;
      bus4.imem_wr_en = 0; bus4.imem_wr_addr = '0; bus4.imem_wr_data = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

      cycle(1, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
      chk_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) load(16'(i), 32'h0);

      // Two-instruction program ending in halt
      load(16'd0, 32'h1801_0005);
      load(16'd1, 32'hFC00_0000);
      pulse_start();
      #1 check("t1_opcode", {26'h0, bus.opcode}, 32'h6);
      check("t1_pc0", bus.pc, 32'h0);
      idle();
      #1 check("t1_pc4", bus.pc, 32'h4);
      check("t1_halt_op", {26'h0, bus.opcode}, 32'h3F);
      idle();
      #1 check("t1_state", {30'h0, bus.state}, 32'h2);
      check("t1_pc_hold", bus.pc, 32'h4);
      check("t1_retired", bus.retired, 32'h2);

      // Branch, stall and jump program
      pulse_start();
      load(16'd0, 32'h0);
      load(16'd1, 32'h0);
      load(16'd2, 32'h0C00_FFFE);
      load(16'd3, 32'h0);
      load(16'd4, 32'h0800_0020);
      load(16'd32, 32'hFC00_0000);
      pulse_start();
      idle();
      idle();
      #1 check("br_instr", bus.instr, 32'h0C00_FFFE);
      cycle(0, 0, 0, 1, 1, 0, 0, 16'h0, 32'h0);
      #1 check("br_taken", bus.pc, 32'h4);
      idle();
      cycle(0, 0, 0, 1, 0, 0, 0, 16'h0, 32'h0);
      #1 check("br_not_taken", bus.pc, 32'hC);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 0, 0, 0, 0, 16'h0, 32'h0);
         #1 check("stall_pc", bus.pc, 32'hC);
         check("stall_ret", bus.retired, 32'd5);
      end
      idle();
      #1 check("stall_release", bus.pc, 32'h10);
      cycle(0, 0, 0, 1, 1, 1, 0, 16'h0, 32'h0);
      #1 check("jump_wins", bus.pc, 32'h80);
      idle();
      #1 check("halt2_state", {30'h0, bus.state}, 32'h2);
      check("halt2_ret", bus.retired, 32'd8);

      // Loader ignored during RUN, reset mid-run keeps memory
      pulse_start();
      pulse_start();
      cycle(0, 0, 0, 0, 0, 0, 1, 16'h0, 32'hDEAD_BEEF);
      idle();
      cycle(1, 0, 0, 0, 0, 0, 1, 16'h0, 32'hDEAD_BEEF);
      #1 check("rst_state", {30'h0, bus.state}, 32'h0);
      check("rst_pc", bus.pc, 32'h0);
      check("rst_ret", bus.retired, 32'h0);
      pulse_start();
      #1 check("mem0_intact", bus.instr, 32'h0);
      idle();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               16'($urandom_range(0, 71)), rand_word());
      end

      // Range fault on a 4-word memory
      @(negedge clk);
      reset4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus4.imem_wr_en = 1; bus4.imem_wr_addr = 16'(i); bus4.imem_wr_data = 32'(i + 1);
      end
      @(negedge clk);
      bus4.imem_wr_en = 0; bus4.start = 1;
      @(negedge clk);
      bus4.start = 0;
      for (int i = 0; i < 4; i++) begin
         #1 check("d4_pc", bus4.pc, 32'(4 * i));
         check("d4_instr", bus4.instr, 32'(i + 1));
         @(negedge clk);
      end
      #1 check("d4_oor_instr", bus4.instr, 32'h0);
      check("d4_oor_state", {30'h0, bus4.state}, 32'h1);
      @(negedge clk);
      #1 check("d4_halt", {30'h0, bus4.state}, 32'h2);
      check("d4_err", {31'h0, bus4.fetch_err}, 32'h1);
      check("d4_ret", bus4.retired, 32'd4);
      check("d4_pc_hold", bus4.pc, 32'h10);
      bus4.start = 1;
      @(negedge clk);
      bus4.start = 0;
      #1 check("d4_clr_state", {30'h0, bus4.state}, 32'h0);
      check("d4_clr_pc", bus4.pc, 32'h0);
      check("d4_clr_err", {31'h0, bus4.fetch_err}, 32'h0);
      check("d4_clr_ret", bus4.retired, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the single-cycle datapath. Holds the PC and an internal word-addressed instruction memory.
- Drives the current instruction, whose bits [31:26] feed the control unit's 6-bit opcode input.
- Computes the next PC from the control unit's branch/jump decisions and the ALU zero flag.
- A small run-control FSM (IDLE/RUN/HALT) gates execution and allows program loading while not running.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words (power of 2, ≤ 2^16).
- RESET_PC, 32'h0000_0000, PC value after reset (word-aligned).
- HALT_OPCODE, 6'b111111, opcode that stops fetch when executed.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; IDLE→RUN
- stall  in  1  hold PC and counters for this cycle (RUN only)
- branch  in  1  Branch from control unit
- zero  in  1  ALU zero flag
- jump  in  1  jump from control unit
- imem_wr_en  in  1  loader write strobe
- imem_wr_addr  in  16  loader word index
- imem_wr_data  in  32  loader data word
- instr  out  32  current instruction
- opcode  out  6  instr[31:26]
- pc  out  32  current PC
- pc_plus4  out  32  pc+4
- state  out  2  00 IDLE, 01 RUN, 10 HALT
- halted  out  1  state==HALT
- fetch_err  out  1  sticky: PC left memory range
- retired  out  32  count of instructions completed in RUN

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, state=IDLE, fetch_err=0, retired=0. Memory contents are not cleared.
- instr/opcode are combinational reads of mem[pc[17:2]] in RUN when in range. Otherwise they are 0 (NOP: control unit deasserts all controls).
- pc_plus4 = pc + 4, mod 2^32 (wraps from FFFF_FFFC to 0).
- Branch offset: sext(instr[15:0]) << 2. Branch target = pc_plus4 + offset, mod 2^32.
- Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
- Next-PC priority in RUN, stall=0:
  - jump → jump target
  - else branch & zero → branch target
  - else pc_plus4
- Each such non-stalled RUN cycle increments retired (wraps at 2^32).
- stall=1 in RUN: pc, retired and state all hold.
- FSM:
  - IDLE: start=1 → RUN. pc holds.
  - RUN, not stalled, opcode==HALT_OPCODE → HALT. pc holds at the halt instruction; retired increments for it.
  - RUN, word index pc>>2 ≥ IMEM_DEPTH → HALT next edge, fetch_err=1. instr=0 that cycle; pc and retired do not change. Checked before stall, so this happens even if stall=1.
  - HALT: start=1 → IDLE with pc=RESET_PC, retired=0, fetch_err=0.
  - start in RUN is ignored.
- Loader: imem_wr_en writes mem[imem_wr_addr] at the edge, only in IDLE or HALT.
  - Ignored in RUN.
  - Ignored when imem_wr_addr ≥ IMEM_DEPTH.
  - A write to the address currently shown is visible on instr only after the FSM enters RUN.
- Simultaneous events:
  - reset dominates start and imem_wr_en.
  - jump and branch both set → jump wins.
  - HALT_OPCODE fetched with stall=1 → no transition until stall drops.
- reset mid-RUN: next edge returns to IDLE at RESET_PC; memory preserved.

Test Plan:
- Reset, then load mem[0]=0x18010005 (opcode 000110), mem[1]=0xFC000000; pulse start → cycle 1 opcode=6'b000110, pc=0; cycle 2 pc=4, opcode=6'b111111; next edge state=HALT, pc=4, retired=2.
- At pc=8, instr=0x0C00FFFE, branch=1, zero=1 → next pc=4. Same with zero=0 → pc=0xC.
- pc=0x10, instr=0x08000020, jump=1, branch=1, zero=1 → next pc=0x80. Jump wins.
- stall=1 for 3 cycles at pc=0xC → pc=0xC and retired unchanged; resumes at 0x10 after release.
- IMEM_DEPTH=4, program with no halt → at pc=0x10 instr=0, then HALT with fetch_err=1, retired=4. A start pulse clears to IDLE, pc=0.
- Loader write with imem_wr_en=1 during RUN (addr 0, data 0xDEADBEEF) → mem unchanged. Reset asserted at cycle 3 of RUN → state=IDLE, pc=0, retired=0, program still intact on restart.
